// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - valid/ready handshake bundle between an upstream producer, stream_fifo and its arbiter lane.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [CNT_WIDTH-1:0]  count_o;

  // FIFO side
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, count_o
  );

  // Environment side: producer upstream, consumer downstream
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, count_o
  );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - registered valid/ready FIFO for a router input port; STREAM_FIFO_BYPASS_EN adds empty fall-through.
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  stream_fifo_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Back-pressure comes from the registered count only, so ready_i never reaches ready_o.
  assign bus.ready_o = !full;
  assign bus.count_o = count;

`ifdef STREAM_FIFO_BYPASS_EN
  assign bus.valid_o = empty ? bus.valid_i : 1'b1;
  assign bus.data_o  = empty ? bus.data_i  : mem[rd_ptr];
  assign bypass      = empty && bus.valid_i && bus.ready_i;
`else
  assign bus.valid_o = !empty;
  assign bus.data_o  = mem[rd_ptr];
  assign bypass      = 1'b0;
`endif

  // A word that falls straight through is never stored, so it is neither a push nor a pop.
  assign push = bus.valid_i && !full && !bypass;
  assign pop  = !empty && bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!arstn_i) count <= CNT_FULL);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!arstn_i) !(pop && empty));

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - bench for stream_fifo (DATA_WIDTH=8, DEPTH=3): vector table, corner sequences, random vs queue model.
module tb_stream_fifo;

  localparam int DW = 8;
  localparam int DP = 3;
`ifdef STREAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] q [$];

  stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          v;
    logic          r;
    logic [DW-1:0] d;
    logic          chk_v;
    logic          ev;
    logic          chk_d;
    logic [DW-1:0] ed;
    logic          erdy;
    int            ecnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cycle: expected outputs and the next queue state follow from the handshake rules alone.
  task automatic mcycle(input logic v, input logic r, input logic [DW-1:0] d);
    logic          byp;
    logic          ev;
    logic [DW-1:0] ed;
    logic          can_push;
    bus.valid_i = v;
    bus.ready_i = r;
    bus.data_i  = d;
    #1;
    byp      = BYP && (q.size() == 0) && v;
    ev       = (q.size() != 0) || byp;
    ed       = (q.size() != 0) ? q[0] : d;
    can_push = v && (q.size() < DP);
    chk("count_o", int'(bus.count_o), q.size());
    chk("ready_o", int'(bus.ready_o), int'(q.size() < DP));
    chk("valid_o", int'(bus.valid_o), int'(ev));
    if (ev) chk("data_o", int'(bus.data_o), int'(ed));
    @(posedge clk_i);
    if (!(byp && r)) begin
      if ((q.size() != 0) && r) void'(q.pop_front());
      if (can_push) q.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    #2 arstn_i = 1'b0;
    #2 arstn_i = 1'b1;
    q.delete();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // cycle: v r d | chk_v ev chk_d ed | ready count
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1};
    tbl[3]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 2};
    tbl[6]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 3};
    tbl[7]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 3};
    tbl[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 2};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 2};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    #12 arstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 12; i++) begin
      bus.valid_i = tbl[i].v;
      bus.ready_i = tbl[i].r;
      bus.data_i  = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d count_o", i), int'(bus.count_o), tbl[i].ecnt);
      chk($sformatf("tbl%0d ready_o", i), int'(bus.ready_o), int'(tbl[i].erdy));
      if (tbl[i].chk_v) chk($sformatf("tbl%0d valid_o", i), int'(bus.valid_o), int'(tbl[i].ev));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d data_o", i), int'(bus.data_o), int'(tbl[i].ed));
      @(posedge clk_i);
      #1;
    end

    // Streaming 0x00..0x09 with one word resident: pointers wrap repeatedly, count stays at 1.
    q.delete();
    mcycle(1'b1, 1'b0, 8'h00);
    for (int i = 1; i < 10; i++) begin
      chk("stream count_o", int'(bus.count_o), 1);
      chk("stream data_o", int'(bus.data_o), i - 1);
      mcycle(1'b1, 1'b1, DW'(i));
    end
    mcycle(1'b0, 1'b1, 8'h00);
    mcycle(1'b0, 1'b0, 8'h00);

    // Asynchronous reset with two words held, then fresh data only.
    mcycle(1'b1, 1'b0, 8'hC1);
    mcycle(1'b1, 1'b0, 8'hC2);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("pre-reset count_o", int'(bus.count_o), 2);
    #2 arstn_i = 1'b0;
    #1;
    chk("async reset valid_o", int'(bus.valid_o), 0);
    chk("async reset count_o", int'(bus.count_o), 0);
    chk("async reset ready_o", int'(bus.ready_o), 1);
    #2 arstn_i = 1'b1;
    q.delete();
    @(posedge clk_i);
    #1;
    mcycle(1'b1, 1'b0, 8'h5A);
    chk("after reset data_o", int'(bus.data_o), 8'h5A);
    chk("after reset count_o", int'(bus.count_o), 1);
    mcycle(1'b0, 1'b1, 8'h00);

    // Empty FIFO offered a word with ready_i high.
    do_reset();
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    bus.data_i  = 8'h77;
    #1;
    chk("empty offer valid_o", int'(bus.valid_o), int'(BYP));
    if (BYP) chk("bypass data_o", int'(bus.data_o), 8'h77);
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    #1;
    chk("empty offer next count_o", int'(bus.count_o), BYP ? 0 : 1);
    chk("empty offer next valid_o", int'(bus.valid_o), BYP ? 0 : 1);
    if (!BYP) chk("empty offer next data_o", int'(bus.data_o), 8'h77);
    do_reset();

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      mcycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0 || i > 2000),
             DW'($urandom));
    end
    for (int i = 0; i < DP + 1; i++) mcycle(1'b0, 1'b1, 8'h00);
    chk("final count_o", int'(bus.count_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
